// File: rtl/ahb_csr_bridge_pkg.sv
// Shared encodings, FSM state type and helpers for the AHB-Lite to CSR bridge.
package ahb_csr_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte mask of an hsize-wide access starting at a byte offset inside a CSR word.
  function automatic logic [7:0] size_byte_mask(input logic [2:0] hsize,
                                                input logic [2:0] offset);
    logic [7:0] m;
    case (hsize)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  // Sizes above 8 bytes are rejected by the size check, so only 3 low bits matter.
  function automatic logic addr_misaligned(input logic [2:0] addr_lo,
                                           input logic [2:0] hsize);
    case (hsize)
      3'd0:    return 1'b0;
      3'd1:    return addr_lo[0];
      3'd2:    return |addr_lo[1:0];
      default: return |addr_lo[2:0];
    endcase
  endfunction

  function automatic bit widths_legal(input int aaw, input int adw,
                                      input int caw, input int cdw);
    return (aaw >= 10) && (aaw <= 64) &&
           ((adw == 32) || (adw == 64) || (adw == 128) || (adw == 256)) &&
           ((cdw == 32) || (cdw == 64)) && (cdw <= adw) &&
           (caw >= $clog2(adw / 8)) && (caw <= aaw);
  endfunction

endpackage

// File: rtl/ahb_csr_lane_mux.sv
// Byte-lane steering between the wide AHB data bus and the narrower CSR bus.
module ahb_csr_lane_mux
  import ahb_csr_bridge_pkg::*;
#(
  parameter int AHB_DATA_WIDTH = 64,
  parameter int CSR_DATA_WIDTH = 32
) (
  input  logic [$clog2(AHB_DATA_WIDTH/8)-1:0] byte_off_i,
  input  logic [2:0]                          hsize_i,
  input  logic [AHB_DATA_WIDTH-1:0]           hwdata_i,
  input  logic [AHB_DATA_WIDTH/8-1:0]         hwstrb_i,
  input  logic [CSR_DATA_WIDTH-1:0]           rdata_i,
  output logic [CSR_DATA_WIDTH-1:0]           wr_data_o,
  output logic [CSR_DATA_WIDTH-1:0]           wr_biten_o,
  output logic [AHB_DATA_WIDTH-1:0]           hrdata_o
);

  localparam int CB   = CSR_DATA_WIDTH / 8;
  localparam int NL   = AHB_DATA_WIDTH / CSR_DATA_WIDTH;
  localparam int AOFF = $clog2(AHB_DATA_WIDTH / 8);
  localparam int COFF = $clog2(CB);

  logic [AOFF-1:0] lane;
  logic [CB-1:0]   bmask;
  logic [CB-1:0]   strb_lane;

  assign lane  = byte_off_i >> COFF;
  assign bmask = CB'(size_byte_mask(hsize_i, 3'(byte_off_i[COFF-1:0])));

  always_comb begin
    wr_data_o = '0;
    strb_lane = '0;
    for (int i = 0; i < NL; i++) begin
      if (lane == AOFF'(i)) begin
        wr_data_o = hwdata_i[i*CSR_DATA_WIDTH +: CSR_DATA_WIDTH];
        strb_lane = hwstrb_i[i*CB +: CB];
      end
    end
  end

  for (genvar b = 0; b < CB; b++) begin : g_biten
    assign wr_biten_o[b*8 +: 8] = {8{strb_lane[b] & bmask[b]}};
  end

  // Reads are replicated so any lane the master selects carries the data.
  assign hrdata_o = {NL{rdata_i}};

endmodule

// File: rtl/ahb_csr_bridge.sv
// AHB-Lite subordinate issuing single CSR req/ack transactions with range,
// size and alignment checks, ack timeout and a two-cycle ERROR response.
module ahb_csr_bridge
  import ahb_csr_bridge_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 64,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int CSR_DATA_WIDTH = 32,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic                        hclk_i,
  input  logic                        hreset_i,
  input  logic [AHB_ADDR_WIDTH-1:0]   haddr_i,
  input  logic [2:0]                  hsize_i,
  input  logic [1:0]                  htrans_i,
  input  logic [AHB_DATA_WIDTH-1:0]   hwdata_i,
  input  logic [AHB_DATA_WIDTH/8-1:0] hwstrb_i,
  input  logic                        hwrite_i,
  input  logic                        hsel_i,
  input  logic                        hready_i,
  output logic [AHB_DATA_WIDTH-1:0]   hrdata_o,
  output logic                        hreadyout_o,
  output logic                        hresp_o,
  output logic                        req_o,
  output logic                        req_is_wr_o,
  output logic [CSR_ADDR_WIDTH-1:0]   addr_o,
  output logic [CSR_DATA_WIDTH-1:0]   wr_data_o,
  output logic [CSR_DATA_WIDTH-1:0]   wr_biten_o,
  input  logic                        req_stall_wr_i,
  input  logic                        req_stall_rd_i,
  input  logic                        rd_ack_i,
  input  logic                        rd_err_i,
  input  logic [CSR_DATA_WIDTH-1:0]   rd_data_i,
  input  logic                        wr_ack_i,
  input  logic                        wr_err_i
);

  if (!widths_legal(AHB_ADDR_WIDTH, AHB_DATA_WIDTH, CSR_ADDR_WIDTH, CSR_DATA_WIDTH)) begin : g_illegal
    $error("ahb_csr_bridge: illegal width parameters");
  end

  localparam int         CB         = CSR_DATA_WIDTH / 8;
  localparam int         AOFF       = $clog2(AHB_DATA_WIDTH / 8);
  localparam int         COFF       = $clog2(CB);
  localparam logic [2:0] CSR_SIZE   = 3'(COFF);
  localparam bit         TIMEOUT_EN = (ACK_TIMEOUT > 0);
  localparam int         TW         = TIMEOUT_EN ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_e                    state_q, state_d;
  logic [CSR_ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [2:0]                hsize_q, hsize_d;
  logic                      hwrite_q, hwrite_d;
  logic [TW-1:0]             cnt_q, cnt_d, cnt_inc;
  logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic capture, addr_err, size_err, align_err, cap_ok;
  logic stall_sel, ack_sel, err_sel, timeout_hit;

  if (CSR_ADDR_WIDTH < AHB_ADDR_WIDTH) begin : g_range
    assign addr_err = |haddr_i[AHB_ADDR_WIDTH-1:CSR_ADDR_WIDTH];
  end else begin : g_full_range
    assign addr_err = 1'b0;
  end

  assign size_err  = (hsize_i > CSR_SIZE);
  assign align_err = addr_misaligned(haddr_i[2:0], hsize_i);
  assign cap_ok    = !(addr_err || size_err || align_err);

  // Only states that drive hreadyout_o high can own an address phase.
  assign capture = hsel_i && hready_i &&
                   ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ)) &&
                   (state_q inside {ST_IDLE, ST_DONE, ST_ERR2});

  assign stall_sel   = hwrite_q ? req_stall_wr_i : req_stall_rd_i;
  assign ack_sel     = hwrite_q ? wr_ack_i : rd_ack_i;
  assign err_sel     = hwrite_q ? wr_err_i : rd_err_i;
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = TIMEOUT_EN && (cnt_inc == TW'(ACK_TIMEOUT));

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    if (capture) begin
      haddr_d  = haddr_i[CSR_ADDR_WIDTH-1:0];
      hsize_d  = hsize_i;
      hwrite_d = hwrite_i;
    end
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (capture) state_d = cap_ok ? ST_REQ : ST_ERR1;
      end
      ST_REQ: begin
        if (!stall_sel) begin
          cnt_d = '0;
          if (ack_sel) begin
            state_d = err_sel ? ST_ERR1 : ST_DONE;
            if (!hwrite_q && !err_sel) rdata_d = rd_data_i;
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        // An ack landing on the timeout cycle still completes the transfer.
        if (ack_sel) begin
          state_d = err_sel ? ST_ERR1 : ST_DONE;
          if (!hwrite_q && !err_sel) rdata_d = rd_data_i;
        end else if (timeout_hit) begin
          state_d = ST_ERR1;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_inc;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_o       = (state_q == ST_REQ);
  assign req_is_wr_o = hwrite_q;
  assign addr_o      = {haddr_q[CSR_ADDR_WIDTH-1:COFF], {COFF{1'b0}}};
  assign hreadyout_o = !(state_q inside {ST_REQ, ST_WAIT_ACK, ST_ERR1});
  assign hresp_o     = (state_q inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;

  ahb_csr_lane_mux #(
    .AHB_DATA_WIDTH (AHB_DATA_WIDTH),
    .CSR_DATA_WIDTH (CSR_DATA_WIDTH)
  ) u_lane_mux (
    .byte_off_i (haddr_q[AOFF-1:0]),
    .hsize_i    (hsize_q),
    .hwdata_i   (hwdata_i),
    .hwstrb_i   (hwstrb_i),
    .rdata_i    (rdata_q),
    .wr_data_o  (wr_data_o),
    .wr_biten_o (wr_biten_o),
    .hrdata_o   (hrdata_o)
  );

endmodule

// File: tb/tb_ahb_csr_bridge.sv
// Directed bench for ahb_csr_bridge (AHB 64 / CSR 32, ACK_TIMEOUT=8).
module tb_ahb_csr_bridge;

  logic        clk = 1'b0;
  logic        hreset;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic        hwrite, hsel;
  logic [63:0] hrdata;
  logic        hreadyout, hresp, req, req_is_wr;
  logic [11:0] addr;
  logic [31:0] wr_data, wr_biten, rd_data;
  logic        stall_wr, stall_rd, rd_ack, rd_err, wr_ack, wr_err;
  wire         hready = hreadyout;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ahb_csr_bridge #(
    .AHB_ADDR_WIDTH (32), .AHB_DATA_WIDTH (64),
    .CSR_ADDR_WIDTH (12), .CSR_DATA_WIDTH (32), .ACK_TIMEOUT (8)
  ) dut (
    .hclk_i (clk), .hreset_i (hreset), .haddr_i (haddr), .hsize_i (hsize),
    .htrans_i (htrans), .hwdata_i (hwdata), .hwstrb_i (hwstrb), .hwrite_i (hwrite),
    .hsel_i (hsel), .hready_i (hready), .hrdata_o (hrdata), .hreadyout_o (hreadyout),
    .hresp_o (hresp), .req_o (req), .req_is_wr_o (req_is_wr), .addr_o (addr),
    .wr_data_o (wr_data), .wr_biten_o (wr_biten), .req_stall_wr_i (stall_wr),
    .req_stall_rd_i (stall_rd), .rd_ack_i (rd_ack), .rd_err_i (rd_err),
    .rd_data_i (rd_data), .wr_ack_i (wr_ack), .wr_err_i (wr_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [31:0] a, input logic [2:0] s, input logic w);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = s; hwrite = w;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    hreset = 1'b1; haddr = '0; hsize = '0; htrans = '0; hwdata = '0; hwstrb = '0;
    hwrite = 1'b0; hsel = 1'b0; stall_wr = 1'b0; stall_rd = 1'b0; rd_ack = 1'b0;
    rd_err = 1'b0; rd_data = '0; wr_ack = 1'b0; wr_err = 1'b0;
    tick(); tick();
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_req", req, 0);
    hreset = 1'b0;

    // unselected and BUSY transfers: zero-wait OKAY, no request
    hsel = 1'b0; htrans = 2'b10; haddr = 32'h4;
    tick();
    chk("unsel_req", req, 0);
    chk("unsel_hready", hreadyout, 1);
    hsel = 1'b1; htrans = 2'b01;
    tick();
    chk("busy_req", req, 0);
    chk("busy_hresp", hresp, 0);

    // word write at 0x004 in upper lane, acked in the accept cycle
    ap(32'h4, 3'd2, 1'b1);
    tick();
    bus_idle(); hwdata = 64'hAABBCCDD_11223344; hwstrb = 8'hF0; wr_ack = 1'b1; #1;
    chk("w1_req", req, 1);
    chk("w1_is_wr", req_is_wr, 1);
    chk("w1_addr", addr, 12'h004);
    chk("w1_wdata", wr_data, 32'hAABBCCDD);
    chk("w1_biten", wr_biten, 32'hFFFFFFFF);
    chk("w1_hready", hreadyout, 0);
    tick();
    wr_ack = 1'b0;
    chk("w1_done_hready", hreadyout, 1);
    chk("w1_done_hresp", hresp, 0);
    chk("w1_done_req", req, 0);

    // byte write at 0x006, address phase pipelined into the DONE cycle
    ap(32'h6, 3'd0, 1'b1);
    tick();
    bus_idle(); hwstrb = 8'h40; wr_ack = 1'b1; #1;
    chk("w2_req", req, 1);
    chk("w2_addr", addr, 12'h004);
    chk("w2_biten", wr_biten, 32'h00FF0000);
    tick();
    wr_ack = 1'b0;
    chk("w2_done_hready", hreadyout, 1);

    // word read at 0x000
    ap(32'h0, 3'd2, 1'b0);
    tick();
    bus_idle(); rd_ack = 1'b1; rd_data = 32'h12345678; #1;
    chk("r1_req", req, 1);
    chk("r1_is_wr", req_is_wr, 0);
    chk("r1_hready", hreadyout, 0);
    tick();
    rd_ack = 1'b0;
    chk("r1_hrdata", hrdata, 64'h12345678_12345678);
    chk("r1_hready_done", hreadyout, 1);
    chk("r1_hresp", hresp, 0);

    // read stalled 3 cycles, acked 2 cycles after acceptance
    ap(32'h8, 3'd2, 1'b0); stall_rd = 1'b1;
    tick();
    bus_idle();
    chk("st_req_c1", req, 1);
    chk("st_addr", addr, 12'h008);
    chk("st_hready_c1", hreadyout, 0);
    tick();
    chk("st_req_c2", req, 1);
    tick();
    chk("st_req_c3", req, 1);
    tick();
    stall_rd = 1'b0;
    chk("st_req_c4", req, 1);
    tick();
    chk("st_req_c5", req, 0);
    chk("st_hready_c5", hreadyout, 0);
    tick();
    rd_ack = 1'b1; rd_data = 32'hCAFEF00D;
    chk("st_hready_c6", hreadyout, 0);
    tick();
    rd_ack = 1'b0;
    chk("st_hready_c7", hreadyout, 1);
    chk("st_hrdata", hrdata, 64'hCAFEF00D_CAFEF00D);

    // out-of-range, misaligned and oversize accesses: two-cycle ERROR
    ap(32'h1000, 3'd2, 1'b0);
    tick();
    bus_idle();
    chk("oor_req", req, 0);
    chk("oor_e1_hresp", hresp, 1);
    chk("oor_e1_hready", hreadyout, 0);
    tick();
    chk("oor_e2_hresp", hresp, 1);
    chk("oor_e2_hready", hreadyout, 1);
    ap(32'h2, 3'd2, 1'b1);
    tick();
    bus_idle();
    chk("mis_req", req, 0);
    chk("mis_e1_hresp", hresp, 1);
    chk("mis_e1_hready", hreadyout, 0);
    tick();
    chk("mis_e2_hready", hreadyout, 1);
    ap(32'h0, 3'd3, 1'b0);
    tick();
    bus_idle();
    chk("sz_e1_hresp", hresp, 1);
    chk("sz_e1_hready", hreadyout, 0);
    tick(); tick();
    chk("err_back_idle_hresp", hresp, 0);
    chk("err_back_idle_hready", hreadyout, 1);

    // timeout after 8 WAIT_ACK cycles; late ack ignored; next read OKAY
    ap(32'hC, 3'd2, 1'b0);
    tick();
    bus_idle();
    chk("to_req", req, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_hready", hreadyout, 0);
      chk("to_wait_hresp", hresp, 0);
      tick();
    end
    rd_ack = 1'b1; rd_data = 32'hDEADBEEF;
    chk("to_e1_hresp", hresp, 1);
    chk("to_e1_hready", hreadyout, 0);
    tick();
    chk("to_e2_hresp", hresp, 1);
    chk("to_e2_hready", hreadyout, 1);
    chk("to_late_ack_hrdata", hrdata, 64'hCAFEF00D_CAFEF00D);
    rd_ack = 1'b0;
    ap(32'h0, 3'd2, 1'b0);
    tick();
    bus_idle(); rd_ack = 1'b1; rd_data = 32'h55AA55AA; #1;
    chk("b2b_req", req, 1);
    tick();
    rd_ack = 1'b0;
    chk("b2b_hresp", hresp, 0);
    chk("b2b_hready", hreadyout, 1);
    chk("b2b_hrdata", hrdata, 64'h55AA55AA_55AA55AA);

    // ack arriving on the timeout cycle wins
    ap(32'h4, 3'd2, 1'b0);
    tick();
    bus_idle();
    tick();
    for (int i = 0; i < 7; i++) tick();
    rd_ack = 1'b1; rd_data = 32'h0F0F0F0F;
    tick();
    rd_ack = 1'b0;
    chk("aw_hresp", hresp, 0);
    chk("aw_hready", hreadyout, 1);
    chk("aw_hrdata", hrdata, 64'h0F0F0F0F_0F0F0F0F);

    // read error returned with ack
    ap(32'h0, 3'd2, 1'b0);
    tick();
    bus_idle(); rd_ack = 1'b1; rd_err = 1'b1;
    tick();
    rd_ack = 1'b0; rd_err = 1'b0;
    chk("rerr_e1_hresp", hresp, 1);
    chk("rerr_e1_hready", hreadyout, 0);
    tick(); tick();

    // write with all-zero bit enables is still issued
    ap(32'h0, 3'd2, 1'b1);
    tick();
    bus_idle(); hwstrb = 8'hF0; #1;
    chk("zb_req", req, 1);
    chk("zb_biten", wr_biten, 32'h0);
    chk("zb_wdata", wr_data, 32'h11223344);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("zb_done_hready", hreadyout, 1);

    // reset during WAIT_ACK with a pending ack
    ap(32'h4, 3'd2, 1'b0);
    tick();
    bus_idle();
    tick();
    chk("rw_wait_hready", hreadyout, 0);
    hreset = 1'b1; rd_ack = 1'b1; rd_data = 32'h11111111;
    tick();
    chk("rw_req", req, 0);
    chk("rw_hready", hreadyout, 1);
    chk("rw_hresp", hresp, 0);
    chk("rw_hrdata", hrdata, 0);
    hreset = 1'b0; rd_ack = 1'b0;
    tick();
    chk("rw_after_req", req, 0);
    chk("rw_after_hready", hreadyout, 1);
    chk("rw_after_hrdata", hrdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
